// File: rtl/alu_mdu.sv
// Multi-cycle execute unit: single-cycle RV32I/RV64I integer ALU plus an
// iterative radix-2 M-extension multiply/divide, valid/ready on both sides.
module alu_mdu #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [4:0]            req_op,
   input  logic [DATA_WIDTH-1:0] req_src1,
   input  logic [DATA_WIDTH-1:0] req_src2,
   input  logic [TAG_WIDTH-1:0]  req_tag,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [TAG_WIDTH-1:0]  rsp_tag
);
   localparam int W   = DATA_WIDTH;
   localparam int SHW = $clog2(DATA_WIDTH);

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_SLL  = 5'd2;
   localparam logic [4:0] OP_SLT  = 5'd3;
   localparam logic [4:0] OP_SLTU = 5'd4;
   localparam logic [4:0] OP_XOR  = 5'd5;
   localparam logic [4:0] OP_SRL  = 5'd6;
   localparam logic [4:0] OP_SRA  = 5'd7;
   localparam logic [4:0] OP_OR   = 5'd8;
   localparam logic [4:0] OP_AND  = 5'd9;
   localparam logic [4:0] OP_LUI  = 5'd10;

   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_e;

   function automatic logic [W-1:0] neg_if(input logic n, input logic [W-1:0] v);
      return n ? (~v + W'(1)) : v;
   endfunction

   function automatic logic [2*W-1:0] neg2_if(input logic n, input logic [2*W-1:0] v);
      return n ? (~v + (2*W)'(1)) : v;
   endfunction

   state_e             state_q;
   logic [SHW-1:0]     cnt_q;
   logic [2*W-1:0]     acc_q;
   logic [W-1:0]       opd_q;
   logic               is_div_q;
   logic               sel_q;
   logic               neg_q;
   logic [W-1:0]       res_q;
   logic [TAG_WIDTH-1:0] tag_q;

   logic signed [W-1:0] src1_s;
   logic signed [W-1:0] src2_s;
   logic [SHW-1:0]      shamt;
   logic                is_mdu, is_div, div_zero, div_ovf, iterative;
   logic                sign1, sign2, sel_hi, neg_res, accept;
   logic [W-1:0]        mag1, mag2, single_d, fix_d;
   logic [2*W-1:0]      iter_d, prod;
   logic [W:0]          mul_sum, div_rem, div_diff;

   assign src1_s = req_src1;
   assign src2_s = req_src2;
   assign shamt  = req_src2[SHW-1:0];

   // Accept-time decode: special divides finish at once, others go iterative
   // on magnitudes with the sign of the selected result remembered.
   assign is_mdu    = (req_op[4:3] == 2'b10);
   assign is_div    = is_mdu & req_op[2];
   assign div_zero  = is_div & (req_src2 == '0);
   assign div_ovf   = is_div & ~req_op[0] & (req_src1 == MOST_NEG) & (req_src2 == '1);
   assign iterative = is_mdu & ~div_zero & ~div_ovf;
   assign sign1     = req_src1[W-1] & (is_div ? ~req_op[0] : (req_op[1:0] != 2'b11));
   assign sign2     = req_src2[W-1] & (is_div ? ~req_op[0] : ~req_op[1]);
   assign mag1      = neg_if(sign1, req_src1);
   assign mag2      = neg_if(sign2, req_src2);
   assign sel_hi    = is_div ? req_op[1] : (req_op[1:0] != 2'b00);
   assign neg_res   = (is_div & req_op[1]) ? sign1 : (sign1 ^ sign2);

   always_comb begin
      single_d = '0;
      case (req_op)
         OP_ADD:  single_d = req_src1 + req_src2;
         OP_SUB:  single_d = req_src1 - req_src2;
         OP_SLL:  single_d = req_src1 << shamt;
         OP_SLT:  single_d = {{(W-1){1'b0}}, (src1_s < src2_s)};
         OP_SLTU: single_d = {{(W-1){1'b0}}, (req_src1 < req_src2)};
         OP_XOR:  single_d = req_src1 ^ req_src2;
         OP_SRL:  single_d = req_src1 >> shamt;
         OP_SRA:  single_d = src1_s >>> shamt;
         OP_OR:   single_d = req_src1 | req_src2;
         OP_AND:  single_d = req_src1 & req_src2;
         OP_LUI:  single_d = req_src2;
         default: single_d = '0;
      endcase
      if (div_zero)
         single_d = req_op[1] ? req_src1 : '1;
      else if (div_ovf)
         single_d = req_op[1] ? '0 : req_src1;
   end

   // acc_q holds {hi, lo}: product/multiplier for MUL, remainder/quotient for DIV.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opd_q} : '0);
      div_rem  = {acc_q[2*W-1:W], acc_q[W-1]};
      div_diff = div_rem - {1'b0, opd_q};
      if (!is_div_q)
         iter_d = {mul_sum, acc_q[W-1:1]};
      else if (div_diff[W])
         iter_d = {div_rem[W-1:0], acc_q[W-2:0], 1'b0};
      else
         iter_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
   end

   assign prod  = neg2_if(neg_q, acc_q);
   assign fix_d = is_div_q ? neg_if(neg_q, sel_q ? acc_q[2*W-1:W] : acc_q[W-1:0])
                           : (sel_q ? prod[2*W-1:W] : prod[W-1:0]);

   assign req_ready = ~flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & rsp_ready));
   assign accept    = req_valid & req_ready;
   assign rsp_valid = (state_q == S_DONE);
   assign rsp_data  = res_q;
   assign rsp_tag   = tag_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opd_q    <= '0;
         is_div_q <= 1'b0;
         sel_q    <= 1'b0;
         neg_q    <= 1'b0;
         res_q    <= '0;
         tag_q    <= '0;
      end else if (flush) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_ITER: begin
               acc_q <= iter_d;
               cnt_q <= cnt_q - SHW'(1);
               if (cnt_q == '0)
                  state_q <= S_FIX;
            end
            S_FIX: begin
               res_q   <= fix_d;
               state_q <= S_DONE;
            end
            default: begin
               if (accept) begin
                  tag_q <= req_tag;
                  if (iterative) begin
                     acc_q    <= {{W{1'b0}}, (is_div ? mag1 : mag2)};
                     opd_q    <= is_div ? mag2 : mag1;
                     is_div_q <= is_div;
                     sel_q    <= sel_hi;
                     neg_q    <= neg_res;
                     cnt_q    <= SHW'(W - 1);
                     state_q  <= S_ITER;
                  end else begin
                     res_q   <= single_d;
                     state_q <= S_DONE;
                  end
               end else if ((state_q == S_DONE) && rsp_ready) begin
                  state_q <= S_IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_mdu.sv
// Randomised and directed bench for alu_mdu at 32 and 64 bits, checked
// against a plain-arithmetic reference model of the RISC-V semantics.
module tb_alu_mdu;
   logic        clk = 1'b0;
   logic        rst, flush;
   logic        req_valid, req_ready, rsp_valid, rsp_ready;
   logic [4:0]  req_op, req_tag, rsp_tag;
   logic [31:0] req_src1, req_src2, rsp_data;
   logic        req_valid_w, req_ready_w, rsp_valid_w, rsp_ready_w;
   logic [4:0]  req_op_w, req_tag_w, rsp_tag_w;
   logic [63:0] req_src1_w, req_src2_w, rsp_data_w;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   alu_mdu #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
      .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag));

   alu_mdu #(.DATA_WIDTH(64), .TAG_WIDTH(5)) dut64 (
      .clk(clk), .rst(rst), .flush(1'b0), .req_valid(req_valid_w), .req_ready(req_ready_w),
      .req_op(req_op_w), .req_src1(req_src1_w), .req_src2(req_src2_w), .req_tag(req_tag_w),
      .rsp_valid(rsp_valid_w), .rsp_ready(rsp_ready_w), .rsp_data(rsp_data_w), .rsp_tag(rsp_tag_w));

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   function automatic logic [31:0] rnd32();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   function automatic logic [31:0] ref32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] p;
      logic        ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         5'd0:  return a + b;
         5'd1:  return a - b;
         5'd2:  return a << b[4:0];
         5'd3:  return {31'b0, (sa < sb)};
         5'd4:  return {31'b0, (a < b)};
         5'd5:  return a ^ b;
         5'd6:  return a >> b[4:0];
         5'd7:  return $signed(a) >>> b[4:0];
         5'd8:  return a | b;
         5'd9:  return a & b;
         5'd10: return b;
         5'd16: begin p = sa * sb; return p[31:0]; end
         5'd17: begin p = sa * sb; return p[63:32]; end
         5'd18: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
         5'd19: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         5'd20: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
         5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         5'd22: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
         5'd23: return (b == 0) ? a : a % b;
         default: return 32'h0;
      endcase
   endfunction

   function automatic int lat32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op < 16 || op > 23) return 0;
      if (op >= 20 && (b == 0 || ((op == 20 || op == 22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 0;
      return 33;
   endfunction

   function automatic logic [63:0] ref64(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
      longint sa, sb;
      logic   ovf;
      sa  = $signed(a);
      sb  = $signed(b);
      ovf = (a == 64'h8000_0000_0000_0000) && (b == '1);
      case (op)
         5'd0:  return a + b;
         5'd20: return (b == 0) ? '1 : ovf ? a : 64'(sa / sb);
         5'd21: return (b == 0) ? '1 : a / b;
         5'd22: return (b == 0) ? a : ovf ? 64'h0 : 64'(sa % sb);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output logic [31:0] d, output logic [4:0] t,
                         output int lat, output bit got);
      int w;
      req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b; req_tag = tag;
      w = 0;
      while (!req_ready && w < 100) begin @(posedge clk); #1; w++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
      got = rsp_valid; d = rsp_data; t = rsp_tag;
      if (got && rsp_ready) begin @(posedge clk); #1; end
   endtask

   task automatic run_op64(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [4:0] tag, output logic [63:0] d, output logic [4:0] t,
                           output int lat, output bit got);
      int w;
      req_valid_w = 1'b1; req_op_w = op; req_src1_w = a; req_src2_w = b; req_tag_w = tag;
      w = 0;
      while (!req_ready_w && w < 100) begin @(posedge clk); #1; w++; end
      @(posedge clk); #1;
      req_valid_w = 1'b0;
      lat = 0;
      while (!rsp_valid_w && lat < 300) begin @(posedge clk); #1; lat++; end
      got = rsp_valid_w; d = rsp_data_w; t = rsp_tag_w;
      if (got && rsp_ready_w) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 1'b1; req_op = 5'd0; req_src1 = 32'd3; req_src2 = 32'd4; req_tag = 5'd7;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_tag !== 5'h0 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_state: valid=%b data=%h tag=%h ready=%b, want 0/0/0/1",
                  rsp_valid, rsp_data, rsp_tag, req_ready);
      end
      req_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      total++;
      if (rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_no_capture: rsp_valid=%b want 0", rsp_valid);
      end
   endtask

   task automatic test_back_to_back();
      vec_t v[5];
      logic [4:0] op;
      logic [31:0] a, b;
      v = '{'{5'd0, 32'hFFFF_FFFF, 32'h1,  32'h0000_0000, 0},
            '{5'd1, 32'h0,         32'h1,  32'hFFFF_FFFF, 0},
            '{5'd7, 32'h8000_0000, 32'h21, 32'hC000_0000, 0},
            '{5'd3, 32'hFFFF_FFFF, 32'h1,  32'h1,         0},
            '{5'd4, 32'hFFFF_FFFF, 32'h1,  32'h0,         0}};
      rsp_ready = 1'b1;
      for (int i = 0; i < 25; i++) begin
         if (i < 5) begin
            op = v[i].op; a = v[i].a; b = v[i].b;
         end else begin
            op = 5'($urandom_range(0, 31));
            if (op >= 16 && op <= 23) op = 5'd24;
            a = rnd32(); b = rnd32();
         end
         req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b; req_tag = 5'(i);
         @(posedge clk); #1;
         total++;
         if (rsp_valid !== 1'b1 || rsp_tag !== 5'(i) ||
             rsp_data !== ((i < 5) ? v[i].exp : ref32(op, a, b))) begin
            bad++;
            $display("FAIL b2b[%0d] op=%0d: valid=%b data=%h tag=%0d, want 1/%h/%0d", i, op,
                     rsp_valid, rsp_data, rsp_tag, (i < 5) ? v[i].exp : ref32(op, a, b), i);
         end
      end
      req_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_mul();
      vec_t v[4];
      logic [31:0] d, a, b;
      logic [4:0]  t, op;
      int          lat;
      bit          got;
      v = '{'{5'd17, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33},
            '{5'd18, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 33},
            '{5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33},
            '{5'd16, 32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33}};
      for (int i = 0; i < 4; i++) begin
         run_op(v[i].op, v[i].a, v[i].b, 5'(i + 3), d, t, lat, got);
         total++;
         if (!got || d !== v[i].exp || t !== 5'(i + 3) || lat != v[i].lat) begin
            bad++;
            $display("FAIL mul_dir[%0d]: got=%b data=%h tag=%0d lat=%0d, want %h/%0d/%0d",
                     i, got, d, t, lat, v[i].exp, i + 3, v[i].lat);
         end
      end
      for (int i = 0; i < 12; i++) begin
         op = 5'(16 + $urandom_range(0, 3)); a = rnd32(); b = rnd32();
         run_op(op, a, b, 5'(i), d, t, lat, got);
         total++;
         if (!got || d !== ref32(op, a, b) || t !== 5'(i) || lat != 33) begin
            bad++;
            $display("FAIL mul_rnd op=%0d a=%h b=%h: data=%h lat=%0d, want %h/33",
                     op, a, b, d, lat, ref32(op, a, b));
         end
      end
   endtask

   task automatic test_div();
      vec_t v[6];
      logic [31:0] d, a, b;
      logic [4:0]  t, op;
      int          lat;
      bit          got;
      v = '{'{5'd20, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33},
            '{5'd22, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 33},
            '{5'd21, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 0},
            '{5'd22, 32'h5,         32'h0,         32'h5,         0},
            '{5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0},
            '{5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         0}};
      for (int i = 0; i < 6; i++) begin
         run_op(v[i].op, v[i].a, v[i].b, 5'(i + 10), d, t, lat, got);
         total++;
         if (!got || d !== v[i].exp || t !== 5'(i + 10) || lat != v[i].lat) begin
            bad++;
            $display("FAIL div_dir[%0d]: got=%b data=%h tag=%0d lat=%0d, want %h/%0d/%0d",
                     i, got, d, t, lat, v[i].exp, i + 10, v[i].lat);
         end
      end
      for (int i = 0; i < 16; i++) begin
         op = 5'(20 + $urandom_range(0, 3)); a = rnd32(); b = rnd32();
         if ($urandom_range(0, 1) == 1) b = 32'($urandom_range(1, 1000));
         run_op(op, a, b, 5'(i), d, t, lat, got);
         total++;
         if (!got || d !== ref32(op, a, b) || t !== 5'(i) || lat != lat32(op, a, b)) begin
            bad++;
            $display("FAIL div_rnd op=%0d a=%h b=%h: data=%h lat=%0d, want %h/%0d",
                     op, a, b, d, lat, ref32(op, a, b), lat32(op, a, b));
         end
      end
   endtask

   task automatic test_random_alu();
      logic [31:0] d, a, b;
      logic [4:0]  t, op;
      int          lat;
      bit          got;
      for (int i = 0; i < 20; i++) begin
         op = 5'($urandom_range(0, 31)); a = rnd32(); b = rnd32();
         run_op(op, a, b, 5'($urandom), d, t, lat, got);
         total++;
         if (!got || d !== ref32(op, a, b) || lat != lat32(op, a, b)) begin
            bad++;
            $display("FAIL rnd op=%0d a=%h b=%h: data=%h lat=%0d, want %h/%0d",
                     op, a, b, d, lat, ref32(op, a, b), lat32(op, a, b));
         end
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_op = 5'd20; req_src1 = 32'hFFFF_FFF9; req_src2 = 32'h2; req_tag = 5'd9;
      @(posedge clk); #1;
      req_valid = 1'b0;
      cyc = 0;
      while (!rsp_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFFD || rsp_tag !== 5'd9) begin
         bad++;
         $display("FAIL bp_result: valid=%b data=%h tag=%0d, want 1/fffffffd/9", rsp_valid, rsp_data, rsp_tag);
      end
      req_valid = 1'b1; req_op = 5'd0; req_src1 = 32'd3; req_src2 = 32'd4; req_tag = 5'd3;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         total++;
         if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFFD || rsp_tag !== 5'd9 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold[%0d]: valid=%b data=%h tag=%0d ready=%b, want 1/fffffffd/9/0",
                     i, rsp_valid, rsp_data, rsp_tag, req_ready);
         end
      end
      rsp_ready = 1'b1;
      #1;
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_release_ready: req_ready=%b want 1", req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd7 || rsp_tag !== 5'd3) begin
         bad++;
         $display("FAIL bp_next_add: valid=%b data=%h tag=%0d, want 1/7/3", rsp_valid, rsp_data, rsp_tag);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_flush();
      logic [31:0] d;
      logic [4:0]  t;
      int          lat, seen;
      bit          got;
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_op = 5'd16; req_src1 = 32'd7; req_src2 = 32'd9; req_tag = 5'd1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      flush = 1'b1;
      req_valid = 1'b1; req_op = 5'd0; req_src1 = 32'd1; req_src2 = 32'd1; req_tag = 5'd2;
      #1;
      total++;
      if (req_ready !== 1'b0) begin
         bad++;
         $display("FAIL flush_ready: req_ready=%b want 0", req_ready);
      end
      @(posedge clk); #1;
      flush = 1'b0; req_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 45; i++) begin
         if (rsp_valid) seen++;
         @(posedge clk); #1;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL flush_silent: rsp_valid cycles=%0d want 0", seen);
      end
      run_op(5'd0, 32'd100, 32'd23, 5'd4, d, t, lat, got);
      total++;
      if (!got || d !== 32'd123 || t !== 5'd4 || lat != 0) begin
         bad++;
         $display("FAIL flush_next_add: data=%h tag=%0d lat=%0d, want 7b/4/0", d, t, lat);
      end
      run_op(5'd16, 32'd6, 32'd7, 5'd5, d, t, lat, got);
      total++;
      if (!got || d !== 32'd42 || t !== 5'd5 || lat != 33) begin
         bad++;
         $display("FAIL flush_next_mul: data=%h tag=%0d lat=%0d, want 2a/5/33", d, t, lat);
      end
   endtask

   task automatic test_async_reset();
      int seen;
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_op = 5'd20; req_src1 = 32'd100; req_src2 = 32'd7; req_tag = 5'd6;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_div: valid=%b ready=%b, want 0/1", rsp_valid, req_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (rsp_valid) seen++;
         @(posedge clk); #1;
      end
      total++;
      if (seen != 0 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_after: valid cycles=%0d ready=%b, want 0/1", seen, req_ready);
      end
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_op = 5'd21; req_src1 = 32'd5; req_src2 = 32'd0; req_tag = 5'd12;
      @(posedge clk); #1;
      req_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_tag !== 5'h0) begin
         bad++;
         $display("FAIL rst_async_drop: valid=%b data=%h tag=%0d, want 0/0/0", rsp_valid, rsp_data, rsp_tag);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      rsp_ready = 1'b1;
   endtask

   task automatic test_w64();
      logic [63:0] d, a, b;
      logic [4:0]  t, op;
      int          lat, elat;
      bit          got;
      rsp_ready_w = 1'b1;
      run_op64(5'd0, '1, 64'd1, 5'd1, d, t, lat, got);
      total++;
      if (!got || d !== 64'h0 || t !== 5'd1 || lat != 0) begin
         bad++;
         $display("FAIL w64_add_wrap: data=%h lat=%0d, want 0/0", d, lat);
      end
      run_op64(5'd20, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd2, d, t, lat, got);
      total++;
      if (!got || d !== 64'hFFFF_FFFF_FFFF_FFFD || t !== 5'd2 || lat != 65) begin
         bad++;
         $display("FAIL w64_div_dir: data=%h lat=%0d, want fffffffffffffffd/65", d, lat);
      end
      run_op64(5'd20, 64'h8000_0000_0000_0000, '1, 5'd3, d, t, lat, got);
      total++;
      if (!got || d !== 64'h8000_0000_0000_0000 || lat != 0) begin
         bad++;
         $display("FAIL w64_div_ovf: data=%h lat=%0d, want 8000000000000000/0", d, lat);
      end
      for (int i = 0; i < 8; i++) begin
         op = (i < 3) ? 5'd0 : 5'(20 + $urandom_range(0, 3));
         a = {$urandom(), $urandom()};
         b = (i == 7) ? 64'h0 : {32'($urandom_range(0, 3)), $urandom()};
         elat = (op == 5'd0 || b == 0) ? 0 : 65;
         run_op64(op, a, b, 5'(i), d, t, lat, got);
         total++;
         if (!got || d !== ref64(op, a, b) || t !== 5'(i) || lat != elat) begin
            bad++;
            $display("FAIL w64_rnd op=%0d a=%h b=%h: data=%h lat=%0d, want %h/%0d",
                     op, a, b, d, lat, ref64(op, a, b), elat);
         end
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0;
      req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0; req_tag = '0; rsp_ready = 1'b1;
      req_valid_w = 1'b0; req_op_w = '0; req_src1_w = '0; req_src2_w = '0; req_tag_w = '0; rsp_ready_w = 1'b1;
      test_reset();
      test_back_to_back();
      test_random_alu();
      test_mul();
      test_div();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_w64();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
